// File: rtl/my_parity_acc_pkg.sv
// -----------------------------------------------------------------------------
// my_parity_acc_pkg
// Shared definitions for the serial parity accumulator:
//   - default FRAME_LEN / CNT_W
//   - FSM state encodings (ST_IDLE=0, ST_ACC=1, ST_HOLD=2)
//   - fold_out(): maps the raw XOR fold onto the reported parity sense
// Optional feature macro: MY_PARITY_ACC_ODD_EN (odd parity when defined).
// -----------------------------------------------------------------------------
package my_parity_acc_pkg;

   localparam int FRAME_LEN_DEF = 8;
   localparam int CNT_W_DEF     = 3;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ACC  = 2'd1,
      ST_HOLD = 2'd2
   } state_t;

   // Odd parity is the inverted fold, so an all-zero frame reports 1.
   function automatic logic fold_out(input logic i_fold);
`ifdef MY_PARITY_ACC_ODD_EN
      return ~i_fold;
`else
      return i_fold;
`endif
   endfunction

endpackage

// File: rtl/my_parity_acc.sv
// -----------------------------------------------------------------------------
// my_parity_acc
// Serial parity accumulator. XOR-folds FRAME_LEN qualified bits per frame and
// presents the resulting parity bit on a valid/ready handshake.
//
// Ports:
//   clk      in   rising-edge clock
//   rst_n    in   asynchronous active-low reset
//   start    in   single-cycle pulse that opens (or restarts) a frame
//   bit_in   in   serial data bit
//   bit_vld  in   bit_in qualifier, one bit consumed per high cycle
//   par_out  out  frame parity result (registered)
//   par_vld  out  par_out valid (registered)
//   par_rdy  in   downstream accepts par_out
//   busy     out  high while accumulating or holding a result (registered)
//   ovr      out  sticky: a bit arrived while a result was being held
//
// Build option: define MY_PARITY_ACC_ODD_EN for odd parity; even otherwise.
// -----------------------------------------------------------------------------
module my_parity_acc
   import my_parity_acc_pkg::*;
#(
   parameter int FRAME_LEN = FRAME_LEN_DEF,
   parameter int CNT_W     = CNT_W_DEF
) (
   input  logic clk,
   input  logic rst_n,
   input  logic start,
   input  logic bit_in,
   input  logic bit_vld,
   output logic par_out,
   output logic par_vld,
   input  logic par_rdy,
   output logic busy,
   output logic ovr
);

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);

   state_t           r_state, w_state_nxt;
   logic             r_acc,   w_acc_nxt;
   logic [CNT_W-1:0] r_cnt,   w_cnt_nxt;
   logic             r_par,   w_par_nxt;
   logic             r_vld,   w_vld_nxt;
   logic             r_ovr,   w_ovr_nxt;
   logic             r_busy;
   logic             w_fold;

   assign w_fold = r_acc ^ bit_in;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_acc   <= 1'b0;
         r_cnt   <= '0;
         r_par   <= 1'b0;
         r_vld   <= 1'b0;
         r_ovr   <= 1'b0;
         r_busy  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_acc   <= w_acc_nxt;
         r_cnt   <= w_cnt_nxt;
         r_par   <= w_par_nxt;
         r_vld   <= w_vld_nxt;
         r_ovr   <= w_ovr_nxt;
         // busy is registered from the next state so it tracks r_state exactly
         r_busy  <= (w_state_nxt != ST_IDLE);
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_acc_nxt   = r_acc;
      w_cnt_nxt   = r_cnt;
      w_par_nxt   = r_par;
      w_vld_nxt   = r_vld;
      w_ovr_nxt   = r_ovr;
      case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_state_nxt = ST_ACC;
               w_acc_nxt   = 1'b0;
               w_cnt_nxt   = '0;
               w_ovr_nxt   = 1'b0;
            end
         end
         ST_ACC: begin
            // start outranks a same-cycle bit: the bit is discarded
            if (start) begin
               w_acc_nxt = 1'b0;
               w_cnt_nxt = '0;
            end else if (bit_vld) begin
               w_acc_nxt = w_fold;
               if (r_cnt == LAST_CNT) begin
                  w_state_nxt = ST_HOLD;
                  w_par_nxt   = fold_out(w_fold);
                  w_vld_nxt   = 1'b1;
                  w_cnt_nxt   = '0;
               end else begin
                  w_cnt_nxt = r_cnt + CNT_W'(1);
               end
            end
         end
         ST_HOLD: begin
            if (bit_vld) w_ovr_nxt = 1'b1;
            if (r_vld && par_rdy) begin
               w_vld_nxt = 1'b0;
               // start is only honoured together with the handshake, giving
               // back-to-back frames without an IDLE bubble
               if (start) begin
                  w_state_nxt = ST_ACC;
                  w_acc_nxt   = 1'b0;
                  w_cnt_nxt   = '0;
                  w_ovr_nxt   = 1'b0;
               end else begin
                  w_state_nxt = ST_IDLE;
               end
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_vld_nxt   = 1'b0;
         end
      endcase
   end

   assign par_out = r_par;
   assign par_vld = r_vld;
   assign busy    = r_busy;
   assign ovr     = r_ovr;

endmodule

// File: tb/tb_my_parity_acc.sv
module tb_my_parity_acc;

`ifdef MY_PARITY_ACC_ODD_EN
   localparam logic ODD = 1'b1;
`else
   localparam logic ODD = 1'b0;
`endif
   localparam int FL = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   logic start = 1'b0, bit_in = 1'b0, bit_vld = 1'b0, par_rdy = 1'b0;
   logic par_out, par_vld, busy, ovr;

   int n_chk = 0;
   int n_fail = 0;

   my_parity_acc #(.FRAME_LEN(FL), .CNT_W(3)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .bit_in(bit_in),
      .bit_vld(bit_vld), .par_out(par_out), .par_vld(par_vld),
      .par_rdy(par_rdy), .busy(busy), .ovr(ovr)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   // mode: 0 = no frame open, 1 = collecting bits, 2 = result waiting
   int   m_mode;
   bit   m_q[$];
   logic m_par, m_vld, m_ovr;

   function automatic logic parity_of_q();
      int ones = 0;
      foreach (m_q[i]) ones += int'(m_q[i]);
      return logic'(ones % 2) ^ ODD;
   endfunction

   function automatic void model_reset();
      m_mode = 0; m_q.delete(); m_par = 0; m_vld = 0; m_ovr = 0;
   endfunction

   function automatic void model_step(input logic s, v, b, r);
      case (m_mode)
         0: if (s) begin m_mode = 1; m_q.delete(); m_ovr = 0; end
         1: begin
            if (s) m_q.delete();
            else if (v) begin
               m_q.push_back(b);
               if (m_q.size() == FL) begin
                  m_par = parity_of_q(); m_vld = 1; m_mode = 2; m_q.delete();
               end
            end
         end
         default: begin
            if (v) m_ovr = 1;
            if (r) begin
               m_vld = 0;
               if (s) begin m_mode = 1; m_q.delete(); m_ovr = 0; end
               else m_mode = 0;
            end
         end
      endcase
   endfunction

   // ---------------- checking helpers ----------------
   task automatic chk(input string name, input logic act, input logic exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
      end
   endtask

   task automatic chk_model(input string tag);
      chk({tag, ".par_out"}, par_out, m_par);
      chk({tag, ".par_vld"}, par_vld, m_vld);
      chk({tag, ".busy"},    busy,    logic'(m_mode != 0));
      chk({tag, ".ovr"},     ovr,     m_ovr);
   endtask

   task automatic drive(input string tag, input logic s, v, b, r);
      start = s; bit_vld = v; bit_in = b; par_rdy = r;
      model_step(s, v, b, r);
      @(posedge clk); #1;
      chk_model(tag);
   endtask

   task automatic do_reset(input string tag);
      rst_n = 0; start = 0; bit_vld = 0; bit_in = 0; par_rdy = 0;
      model_reset();
      #1;
      chk({tag, ".par_out"}, par_out, 1'b0);
      chk({tag, ".par_vld"}, par_vld, 1'b0);
      chk({tag, ".busy"},    busy,    1'b0);
      chk({tag, ".ovr"},     ovr,     1'b0);
      @(posedge clk); #1;
      rst_n = 1;
   endtask

   typedef struct {
      logic s, v, b, r;
      logic ev, ep, eb, eo;
   } vec_t;

   initial begin
      vec_t tv[10];
      logic t1b[8];
      logic t4b[8];
      logic held;

      // Test 1 table: start, bits 1,0,1,1,0,0,0,0, handshake
      t1b = '{1, 0, 1, 1, 0, 0, 0, 0};
      tv[0] = '{s:1, v:0, b:0, r:0, ev:0, ep:0, eb:1, eo:0};
      for (int i = 0; i < 8; i++)
         tv[i+1] = '{s:0, v:1, b:t1b[i], r:0, ev:(i == 7), ep:((i == 7) ? 1'b1 ^ ODD : 1'b0),
                     eb:1, eo:0};
      tv[9] = '{s:0, v:0, b:0, r:1, ev:0, ep:1'b1 ^ ODD, eb:0, eo:0};

      #2;
      do_reset("reset");

      for (int i = 0; i < 10; i++) begin
         drive("t1", tv[i].s, tv[i].v, tv[i].b, tv[i].r);
         chk($sformatf("t1[%0d].par_vld", i), par_vld, tv[i].ev);
         chk($sformatf("t1[%0d].par_out", i), par_out, tv[i].ep);
         chk($sformatf("t1[%0d].busy", i),    busy,    tv[i].eb);
         chk($sformatf("t1[%0d].ovr", i),     ovr,     tv[i].eo);
      end

      // Test 2: all-zero frame, one bit every third cycle
      drive("t2", 1, 0, 0, 0);
      for (int i = 0; i < FL; i++) begin
         drive("t2", 0, 1, 0, 0);
         chk("t2.vld_timing", par_vld, logic'(i == FL - 1));
         if (i != FL - 1) begin
            drive("t2", 0, 0, 1, 1);
            drive("t2", 0, 0, 1, 1);
         end
      end
      chk("t2.zero_par", par_out, ODD);
      drive("t2", 0, 0, 0, 1);

      // Test 3: backpressure with a stray bit while holding
      drive("t3", 1, 0, 0, 0);
      for (int i = 0; i < FL; i++) drive("t3", 0, 1, 1'($urandom_range(0, 1)), 0);
      held = par_out;
      for (int i = 0; i < 5; i++) begin
         drive("t3", 0, logic'(i == 1), 1, 0);
         chk("t3.hold_vld", par_vld, 1'b1);
         chk("t3.hold_par", par_out, held);
      end
      chk("t3.ovr_set", ovr, 1'b1);
      drive("t3", 0, 0, 0, 1);
      chk("t3.vld_drop", par_vld, 1'b0);
      chk("t3.ovr_sticky", ovr, 1'b1);
      drive("t3", 0, 1, 1, 0);
      chk("t3.ovr_idle", ovr, 1'b1);
      drive("t3", 1, 0, 0, 0);
      chk("t3.ovr_clr", ovr, 1'b0);

      // Test 4: restart after 4 bits discards them
      drive("t4", 0, 1, 1, 0);
      drive("t4", 0, 1, 1, 0);
      drive("t4", 0, 1, 1, 0);
      drive("t4", 0, 1, 0, 0);
      drive("t4", 1, 1, 1, 0);
      t4b = '{1, 0, 0, 0, 0, 0, 0, 0};
      for (int i = 0; i < FL; i++) drive("t4", 0, 1, t4b[i], 0);
      chk("t4.vld", par_vld, 1'b1);
      chk("t4.par", par_out, 1'b1 ^ ODD);

      // Test 5: handshake + start in the same cycle, then 8 ones
      drive("t5", 1, 0, 0, 1);
      chk("t5.no_bubble", busy, 1'b1);
      chk("t5.vld_drop", par_vld, 1'b0);
      for (int i = 0; i < FL; i++) begin
         drive("t5", 0, 1, 1, 0);
         chk("t5.vld_timing", par_vld, logic'(i == FL - 1));
      end
      chk("t5.par", par_out, ODD);
      drive("t5", 0, 0, 0, 1);

      // Test 6: reset mid-frame, then bits without a start
      drive("t6", 1, 0, 0, 0);
      for (int i = 0; i < 5; i++) drive("t6", 0, 1, 1, 0);
      do_reset("t6.rst");
      for (int i = 0; i < 10; i++) begin
         drive("t6", 0, 1, 1, 1);
         chk("t6.no_vld", par_vld, 1'b0);
      end

      // Randomized run against the model
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 499) == 0) do_reset("rnd.rst");
         else drive("rnd", logic'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), logic'($urandom_range(0, 2) != 0));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
